xor_scrambled_ram: RTL and testbench
====================================

Name: xor_scrambled_ram

Overview:
- Parametrised single-port RAM storing every word XOR-scrambled with a secret key held in a dedicated key register, not in the array, so all 2^AW words are usable.
- Reads return the descrambled data.
- Loading a new key starts a hardware re-key walk that re-scrambles every stored word in place, so plaintext survives key rotation.
- Sits between processor-side datapath logic and on-chip block RAM as a lab-grade secure scratch store.

Parameters:
- DW, 32, data word width in bits
- AW, 8, address width; DEPTH = 2^AW words
- KEY_RST, 0, key register value after reset (DW bits)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- we  in  1  write request
- re  in  1  read request
- a  in  AW  word address
- d  in  DW  plaintext write data
- q  out  DW  plaintext read data, registered
- q_valid  out  1  one-cycle pulse: q valid
- key_we  in  1  load new key / start re-key
- key_d  in  DW  new key value
- busy  out  1  re-key walk in progress; requests ignored
- rekey_done  out  1  one-cycle pulse at end of re-key
- parity_err  out  1  parity mismatch on read (PARITY_EN only)

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset:
  - key=KEY_RST, FSM=IDLE, q=0, q_valid=0, busy=0, rekey_done=0, parity_err=0.
  - Array contents are not cleared.
- FSM states: IDLE, RD, WR, DONE. busy = (state != IDLE).
- IDLE priority: key_we > we > re. Lower-priority requests in the same cycle are dropped, not queued.
- Write (IDLE, we=1):
  - mem[a] <= d ^ key at the clock edge.
  - No response on q or q_valid.
- Read (IDLE, re=1, we=0):
  - q <= mem[a] ^ key; q_valid=1 the next cycle, for exactly one cycle (latency 1).
  - q holds its value until the next read.
- Key load (IDLE, key_we=1):
  - Latch new_key=key_d, cnt=0, go to RD.
- RD:
  - buf <= mem[cnt]; go to WR.
- WR:
  - mem[cnt] <= buf ^ key ^ new_key.
  - If cnt==DEPTH-1, go to DONE; else cnt++ and go to RD.
- DONE:
  - rekey_done=1 for this one cycle; key <= new_key at the end of the cycle; go to IDLE.
- Walk timing: key_we sampled at edge T gives busy=1 from T+1 for 2*DEPTH+1 cycles (513 at AW=8). rekey_done is high in the last busy cycle.
- While busy:
  - we, re and key_we are ignored.
  - q holds its value; q_valid=0.
- cnt is AW bits wide. The terminal compare is on DEPTH-1, so there is no wrap beyond the last address.
- Reset during a walk:
  - Aborts immediately and key returns to KEY_RST.
  - Array is partially re-keyed; contents are undefined and software must rewrite them.
- Key load with key_d == current key: the full walk still runs and data is unchanged.

Optional Feature:
- Macro: XOR_SCRAMBLED_RAM_PARITY_EN.
- When defined:
  - Array is DW+1 bits wide; bit DW holds even parity of the stored (scrambled) word.
  - Computed on every write and every WR-state rewrite.
  - On a read, parity_err=1 together with q_valid if the stored parity mismatches; q is still delivered.
- When undefined:
  - Array is DW bits wide and parity_err is tied to 0.

Test Plan:
- Reset, then write a=5 d=0xDEADBEEF, read a=5 -> q=0xDEADBEEF with q_valid pulse exactly 1 cycle after re.
- key_we key_d=0xFFFF0000, then write a=7 d=0x12345678 after done; raw mem[7] (hierarchical) = 0xEDCB5678; read a=7 -> 0x12345678.
- Fill a=0..255 with d=a*3, key_we key_d=0xA5A5A5A5 -> busy high 513 cycles, rekey_done pulse in last busy cycle; read all -> a*3 unchanged.
- During busy, assert we a=0 d=0x1 and re a=0 -> no q_valid, mem[0] plaintext unchanged after walk.
- Same cycle we=1, re=1, key_we=1 in IDLE -> re-key starts, write and read dropped.
- Assert rst at walk cycle 100 -> next cycle busy=0, key=KEY_RST, rekey_done never pulses. With XOR_SCRAMBLED_RAM_PARITY_EN: force-flip bit 0 of mem[5], read a=5 -> parity_err=1 with q_valid.

Source files
------------

// File: rtl/xor_scrambled_ram.sv
// Single-port RAM whose words are stored XOR-scrambled with a key register.
// Optional stored-word parity: define XOR_SCRAMBLED_RAM_PARITY_EN.
module xor_scrambled_ram #(
  parameter int          DW      = 32,
  parameter int          AW      = 8,
  parameter logic [DW-1:0] KEY_RST = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          q_valid,
  input  logic          key_we,
  input  logic [DW-1:0] key_d,
  output logic          busy,
  output logic          rekey_done,
  output logic          parity_err
);

  localparam int DEPTH = 1 << AW;
`ifdef XOR_SCRAMBLED_RAM_PARITY_EN
  localparam int MW = DW + 1;
`else
  localparam int MW = DW;
`endif

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] key;
  logic [DW-1:0] new_key;
  logic [DW-1:0] rd_buf;
  logic [AW-1:0] cnt;
  logic [MW-1:0] mem [DEPTH];

  logic          idle;
  logic          do_wr;
  logic          do_rd;
  logic          mem_we;
  logic [AW-1:0] addr;
  logic [MW-1:0] rdata;
  logic [MW-1:0] wdata;
  logic [DW-1:0] wword;

  assign idle  = (state == IDLE);
  assign do_wr = idle & ~key_we & we;
  assign do_rd = idle & ~key_we & ~we & re;

  // The walk owns the single port while busy.
  assign addr   = idle ? a : cnt;
  assign rdata  = mem[addr];
  assign wword  = idle ? (d ^ key) : (rd_buf ^ key ^ new_key);
  assign mem_we = ~rst & (do_wr | (state == WR));

  assign busy       = ~idle;
  assign rekey_done = (state == DONE);

`ifdef XOR_SCRAMBLED_RAM_PARITY_EN
  logic perr_q;

  assign wdata      = {^wword, wword};
  assign parity_err = perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= do_rd & (^rdata);
    end
  end
`else
  assign wdata      = wword;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      key     <= KEY_RST;
      new_key <= '0;
      rd_buf  <= '0;
      cnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
    end else begin
      q_valid <= do_rd;
      if (do_rd) begin
        q <= rdata[DW-1:0] ^ key;
      end
      unique case (state)
        IDLE: begin
          if (key_we) begin
            new_key <= key_d;
            cnt     <= '0;
            state   <= RD;
          end
        end
        RD: begin
          rd_buf <= rdata[DW-1:0];
          state  <= WR;
        end
        WR: begin
          if (&cnt) begin
            state <= DONE;
          end else begin
            cnt   <= cnt + 1'b1;
            state <= RD;
          end
        end
        DONE: begin
          key   <= new_key;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_scrambled_ram.sv
// Randomized bench for xor_scrambled_ram against a plaintext array model.
// Keeps its own copy of the key to check the raw scrambled contents.
module tb_xor_scrambled_ram;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          we;
  logic          re;
  logic [AW-1:0] a;
  logic [DW-1:0] d;
  logic [DW-1:0] q;
  logic          q_valid;
  logic          key_we;
  logic [DW-1:0] key_d;
  logic          busy;
  logic          rekey_done;
  logic          parity_err;

  int checks   = 0;
  int failures = 0;
  int done_pulses = 0;

  logic [DW-1:0] model [DEPTH];
  bit            known [DEPTH];
  logic [DW-1:0] mkey;

  xor_scrambled_ram #(
    .DW(DW),
    .AW(AW),
    .KEY_RST('0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .re(re),
    .a(a),
    .d(d),
    .q(q),
    .q_valid(q_valid),
    .key_we(key_we),
    .key_d(key_d),
    .busy(busy),
    .rekey_done(rekey_done),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rekey_done === 1'b1) done_pulses++;
  end

  task automatic chk(input string tag,
                     input logic [DW-1:0] got,
                     input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] ad,
                          input logic [DW-1:0] dd);
    @(negedge clk);
    we = 1'b1;
    a  = ad;
    d  = dd;
    @(negedge clk);
    we = 1'b0;
    chk("wr_no_qvalid", q_valid, 0);
    model[ad] = dd;
    known[ad] = 1'b1;
  endtask

  task automatic do_read(input logic [AW-1:0] ad);
    @(negedge clk);
    re = 1'b1;
    a  = ad;
    @(negedge clk);
    re = 1'b0;
    chk("rd_qvalid", q_valid, 1);
    if (known[ad]) chk("rd_data", q, model[ad]);
    chk("rd_parity", parity_err, 0);
    @(negedge clk);
    chk("rd_qvalid_pulse", q_valid, 0);
  endtask

  task automatic chk_raw(input logic [AW-1:0] ad);
    if (known[ad]) chk("raw_mem", dut.mem[ad][DW-1:0], model[ad] ^ mkey);
  endtask

  task automatic rekey(input logic [DW-1:0] k,
                       input bit noisy,
                       input bit clash);
    int n;
    int done_at;
    int qv_bad;
    @(negedge clk);
    key_we = 1'b1;
    key_d  = k;
    if (clash) begin
      we = 1'b1;
      re = 1'b1;
      a  = 8'd9;
      d  = ~model[9];
    end
    @(negedge clk);
    key_we  = 1'b0;
    we      = 1'b0;
    re      = 1'b0;
    n       = 0;
    done_at = -1;
    qv_bad  = 0;
    while (busy === 1'b1 && n < 2000) begin
      if (rekey_done === 1'b1) done_at = n;
      if (q_valid !== 1'b0) qv_bad++;
      if (noisy) begin
        we     = 1'b1;
        re     = 1'b1;
        a      = '0;
        d      = 32'h1;
        key_we = 1'b1;
        key_d  = ~k;
      end
      @(negedge clk);
      n++;
    end
    we     = 1'b0;
    re     = 1'b0;
    key_we = 1'b0;
    chk("busy_len", 32'(n), 32'd513);
    chk("done_at_last", 32'(done_at), 32'd512);
    chk("busy_no_qvalid", 32'(qv_bad), 0);
    chk("done_low_after", rekey_done, 0);
    mkey = k;
  endtask

  task automatic rst_mid_walk();
    int n;
    int p0;
    @(negedge clk);
    key_we = 1'b1;
    key_d  = 32'h0BAD_F00D;
    @(negedge clk);
    key_we = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("walk_reached_100", 32'(n), 32'd100);
    p0  = done_pulses;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_key", dut.key, 0);
    chk("abort_done", rekey_done, 0);
    rst = 1'b0;
    repeat (600) @(negedge clk);
    chk("abort_no_done_pulse", 32'(done_pulses - p0), 0);
    chk("abort_idle", busy, 0);
    mkey = '0;
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [DW-1:0] rd;
    rst    = 1'b1;
    we     = 1'b0;
    re     = 1'b0;
    key_we = 1'b0;
    a      = '0;
    d      = '0;
    key_d  = '0;
    mkey   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      known[i] = 1'b0;
      model[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk("rst_q", q, 0);
    chk("rst_qvalid", q_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", rekey_done, 0);
    chk("rst_parity", parity_err, 0);
    chk("rst_key", dut.key, 0);
    rst = 1'b0;

    do_write(8'd5, 32'hDEADBEEF);
    do_read(8'd5);

    rekey(32'hFFFF0000, 1'b0, 1'b0);
    do_write(8'd7, 32'h12345678);
    chk("raw_mem7", dut.mem[7][DW-1:0], 32'hEDCB5678);
    do_read(8'd7);

    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 32'(i * 3));
    rekey(32'hA5A5A5A5, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      do_read(AW'(i));
      chk_raw(AW'(i));
    end

    rekey($urandom, 1'b0, 1'b1);
    do_read(8'd9);
    chk_raw(8'd9);

    rekey(mkey, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) do_read(AW'($urandom_range(0, DEPTH - 1)));

    rst_mid_walk();

    for (int i = 0; i < 400; i++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      rd = $urandom;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_write(ra, rd);
        9:          chk_raw(ra);
        default:    do_read(ra);
      endcase
      if (i == 200) rekey($urandom, 1'b0, 1'b0);
    end
    for (int i = 0; i < DEPTH; i++) chk_raw(AW'(i));

`ifdef XOR_SCRAMBLED_RAM_PARITY_EN
    do_write(8'd5, 32'h0F0F_1234);
    @(negedge clk);
    dut.mem[5][0] = ~dut.mem[5][0];
    re = 1'b1;
    a  = 8'd5;
    @(negedge clk);
    re = 1'b0;
    chk("perr_qvalid", q_valid, 1);
    chk("perr_flag", parity_err, 1);
    chk("perr_data", q, model[5] ^ 32'h1);
    do_write(8'd5, 32'h0F0F_1234);
    do_read(8'd5);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
